// File: rtl/sobel_seq_pkg.sv
// sobel_seq_pkg: state encodings and protocol bytes shared by the Sobel frame sequencer.
package sobel_seq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_TRAIL} seq_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_WAIT_HI, TX_WAIT_LO} tx_state_e;
   localparam logic [7:0] SYNC_BYTE    = 8'hA5;
   localparam logic [7:0] TRAILER_BYTE = 8'h5A;
endpackage

// File: rtl/sobel_frame_sequencer_fifo.sv
// seq_byte_fifo: show-ahead byte FIFO (power-of-two depth >= 2) with synchronous flush.
module seq_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [NW-1:0] cnt_q;
   logic          do_push, do_pop;
   assign full_o  = cnt_q == NW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign data_o  = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + NW'(do_push) - NW'(do_pop);
      end
   end
endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: frame sync, interior tagging of filter results and paced UART return.
// Define SOBEL_SEQ_TRAILER_EN to append 0x5A and a completed-frame count after each frame.
module sobel_frame_sequencer
   import sobel_seq_pkg::*;
#(
   parameter int IMG_W       = 320,
   parameter int IMG_H       = 240,
   parameter int FILT_LAT    = 1,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       filt_clear_o,
   output logic [7:0] filt_in_data_o,
   output logic       filt_in_valid_o,
   input  logic [7:0] filt_out_data_i,
   input  logic       filt_out_valid_i,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   input  logic       tx_busy_i,
   output logic       frame_active_o,
   output logic       frame_done_o,
   output logic       err_timeout_o,
   output logic       err_overflow_o
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   seq_state_e    state_q;
   tx_state_e     tx_q, tx_d;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [TW-1:0] to_cnt_q;
   logic          tag_in_q;
   logic [FILT_LAT-1:0] tag_q;
   logic       filt_clear_q, filt_in_valid_q, tx_start_q, frame_done_q, err_timeout_q, err_overflow_q;
   logic [7:0] filt_in_data_q, tx_data_q, fifo_dout, tx_byte;
   logic       rx_sync, last_px, col_wrap, timeout, pipe_empty, drain_ok;
   logic       fifo_push, fifo_pop, fifo_full, fifo_empty, tx_avail, tx_go;
   assign rx_sync    = rx_valid_i && rx_data_i == SYNC_BYTE;
   assign col_wrap   = col_q == CW'(IMG_W - 1);
   assign last_px    = col_wrap && row_q == RW'(IMG_H - 1);
   assign timeout    = state_q == S_RECV && !rx_valid_i && to_cnt_q == TW'(TIMEOUT_CYC - 1);
   assign pipe_empty = !tag_in_q && tag_q == '0;
   assign fifo_push  = filt_out_valid_i && tag_q[FILT_LAT-1];
   assign drain_ok   = pipe_empty && fifo_empty && tx_q == TX_IDLE && !tx_busy_i;
`ifdef SOBEL_SEQ_TRAILER_EN
   logic [1:0] trail_idx_q;
   logic [7:0] frame_cnt_q;
   logic       in_trail;
   assign in_trail = state_q == S_TRAIL;
   assign tx_avail = in_trail ? trail_idx_q != 2'd2 : !fifo_empty;
   assign tx_byte  = !in_trail ? fifo_dout : trail_idx_q == 2'd0 ? TRAILER_BYTE : frame_cnt_q;
   assign fifo_pop = tx_go && !in_trail;
`else
   assign tx_avail = !fifo_empty;
   assign tx_byte  = fifo_dout;
   assign fifo_pop = tx_go;
`endif
   assign tx_go = tx_q == TX_IDLE && !tx_busy_i && tx_avail;
   assign tx_d  = tx_go ? TX_WAIT_HI
                : (tx_q == TX_WAIT_HI && tx_busy_i) ? TX_WAIT_LO
                : (tx_q == TX_WAIT_LO && !tx_busy_i) ? TX_IDLE : tx_q;
   seq_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (timeout),
      .push_i  (fifo_push),
      .data_i  (filt_out_data_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= S_IDLE;
         tx_q            <= TX_IDLE;
         col_q           <= '0;
         row_q           <= '0;
         to_cnt_q        <= '0;
         tag_in_q        <= 1'b0;
         tag_q           <= '0;
         filt_clear_q    <= 1'b0;
         filt_in_valid_q <= 1'b0;
         filt_in_data_q  <= '0;
         tx_start_q      <= 1'b0;
         tx_data_q       <= '0;
         frame_done_q    <= 1'b0;
         err_timeout_q   <= 1'b0;
         err_overflow_q  <= 1'b0;
`ifdef SOBEL_SEQ_TRAILER_EN
         trail_idx_q     <= '0;
         frame_cnt_q     <= '0;
`endif
      end else begin
         filt_clear_q    <= 1'b0;
         filt_in_valid_q <= 1'b0;
         frame_done_q    <= 1'b0;
         tag_in_q        <= 1'b0;
         tag_q           <= timeout ? '0 : (tag_q << 1) | FILT_LAT'(tag_in_q);
         tx_q            <= tx_d;
         tx_start_q      <= tx_go;
         if (tx_go) tx_data_q <= tx_byte;
         if (fifo_push && fifo_full) err_overflow_q <= 1'b1;
         case (state_q)
            S_IDLE: if (rx_sync) begin
               state_q        <= S_RECV;
               col_q          <= '0;
               row_q          <= '0;
               to_cnt_q       <= '0;
               err_timeout_q  <= 1'b0;
               err_overflow_q <= 1'b0;
               filt_clear_q   <= 1'b1;
            end
            S_RECV: if (timeout) begin
               state_q       <= S_IDLE;
               err_timeout_q <= 1'b1;
            end else if (rx_valid_i) begin
               filt_in_valid_q <= 1'b1;
               filt_in_data_q  <= rx_data_i;
               tag_in_q        <= row_q >= RW'(2) && col_q >= CW'(2);
               to_cnt_q        <= '0;
               col_q           <= col_wrap ? '0 : col_q + 1'b1;
               row_q           <= row_q + RW'(col_wrap);
               if (last_px) state_q <= S_DRAIN;
            end else begin
               to_cnt_q <= to_cnt_q + 1'b1;
            end
`ifdef SOBEL_SEQ_TRAILER_EN
            S_DRAIN: if (drain_ok) begin
               state_q     <= S_TRAIL;
               trail_idx_q <= '0;
               frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            S_TRAIL: if (tx_go) begin
               trail_idx_q <= trail_idx_q + 1'b1;
            end else if (trail_idx_q == 2'd2 && drain_ok) begin
               state_q      <= S_IDLE;
               frame_done_q <= 1'b1;
            end
`else
            S_DRAIN: if (drain_ok) begin
               state_q      <= S_IDLE;
               frame_done_q <= 1'b1;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign filt_clear_o    = filt_clear_q;
   assign filt_in_data_o  = filt_in_data_q;
   assign filt_in_valid_o = filt_in_valid_q;
   assign tx_data_o       = tx_data_q;
   assign tx_start_o      = tx_start_q;
   assign frame_active_o  = state_q != S_IDLE;
   assign frame_done_o    = frame_done_q;
   assign err_timeout_o   = err_timeout_q;
   assign err_overflow_o  = err_overflow_q;
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: directed frames against an echo filter and a 10-cycle UART busy model.
module tb_sobel_frame_sequencer;
`ifdef SOBEL_SEQ_TRAILER_EN
   localparam int TRL = 2;
`else
   localparam int TRL = 0;
`endif
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       filt_clear, filt_in_valid, filt_out_valid = 1'b0;
   logic [7:0] filt_in_data, filt_out_data = '0, tx_data;
   logic       tx_start, tx_busy, hold_busy = 1'b0;
   logic       frame_active, frame_done, err_timeout, err_overflow;
   logic [31:0] exp_tx;
   logic [7:0] sb [$];
   int n_cmp = 0, n_bad = 0, busy_cnt = 0, exp_frames = 0;
   int tx_cnt = 0, fin_cnt = 0, clr_cnt = 0, done_cnt = 0, tx0, f0, d0;

   always #5 clk = ~clk;
   assign tx_busy = hold_busy || busy_cnt != 0;

   sobel_frame_sequencer #(
      .IMG_W(4), .IMG_H(4), .FILT_LAT(1), .FIFO_DEPTH(2), .TIMEOUT_CYC(100)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .rx_data_i       (rx_data),
      .rx_valid_i      (rx_valid),
      .filt_clear_o    (filt_clear),
      .filt_in_data_o  (filt_in_data),
      .filt_in_valid_o (filt_in_valid),
      .filt_out_data_i (filt_out_data),
      .filt_out_valid_i(filt_out_valid),
      .tx_data_o       (tx_data),
      .tx_start_o      (tx_start),
      .tx_busy_i       (tx_busy),
      .frame_active_o  (frame_active),
      .frame_done_o    (frame_done),
      .err_timeout_o   (err_timeout),
      .err_overflow_o  (err_overflow)
   );

   always @(posedge clk) begin
      filt_out_valid <= filt_in_valid;
      filt_out_data  <= filt_in_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (filt_in_valid) fin_cnt++;
      if (filt_clear) clr_cnt++;
      if (frame_done) done_cnt++;
      if (tx_start) begin
         tx_cnt++;
         chk("tx_start_while_busy", 32'(tx_busy), 0);
         exp_tx = 32'h1FF;
         if (sb.size() != 0) exp_tx = 32'(sb.pop_front());
         chk("tx_data", 32'(tx_data), exp_tx);
      end
      busy_cnt = tx_start ? 10 : busy_cnt > 0 ? busy_cnt - 1 : 0;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
   endtask

   // Interior pixels of a 4x4 frame are indices 10, 11, 14, 15; keep limits how many survive.
   task automatic frame(input logic [7:0] base, input int gap, input int keep);
      send(8'hA5);
      for (int i = 0; i < 16; i++) begin
         if (i / 4 >= 2 && i % 4 >= 2 && keep > 0) begin
            sb.push_back(base + 8'(i));
            keep--;
         end
         send(base + 8'(i));
         step(gap);
      end
      if (TRL != 0) begin
         exp_frames++;
         sb.push_back(8'h5A);
         sb.push_back(8'(exp_frames));
      end
   endtask

   task automatic wait_done(input string tag);
      int start = done_cnt;
      for (int i = 0; i < 1000 && done_cnt == start; i++) step(1);
      chk(tag, done_cnt, start + 1);
   endtask

   function automatic logic [31:0] all_outs();
      return {9'd0, filt_clear, filt_in_valid, tx_start, frame_active, frame_done,
              err_timeout, err_overflow, filt_in_data, tx_data};
   endfunction

   initial begin
      step(3);
      chk("reset_outputs", all_outs(), 0);
      rst_n = 1'b1;
      step(2);
      chk("idle_after_reset", all_outs(), 0);

      frame(8'h00, 12, 4);
      wait_done("t1_done");
      chk("t1_clear_pulses", clr_cnt, 1);
      chk("t1_tx_count", tx_cnt, 4 + TRL);
      chk("t1_sb_empty", sb.size(), 0);
      chk("t1_active_low", 32'(frame_active), 0);

      f0 = fin_cnt;
      send(8'h11);
      send(8'h22);
      step(2);
      chk("t2_junk_not_forwarded", fin_cnt - f0, 0);
      chk("t2_junk_stays_idle", 32'(frame_active), 0);
      tx0 = tx_cnt;
      frame(8'h20, 12, 4);
      wait_done("t2_done");
      chk("t2_filt_in_pulses", fin_cnt - f0, 16);
      chk("t2_tx_count", tx_cnt - tx0, 4 + TRL);
      chk("t2_clear_pulses", clr_cnt, 2);

      hold_busy = 1'b1;
      tx0 = tx_cnt;
      frame(8'h40, 0, 2);
      step(20);
      chk("t3_overflow", 32'(err_overflow), 1);
      chk("t3_no_tx_while_busy", tx_cnt - tx0, 0);
      chk("t3_held_in_drain", 32'(frame_active), 1);
      hold_busy = 1'b0;
      wait_done("t3_done");
      chk("t3_tx_count", tx_cnt - tx0, 2 + TRL);
      chk("t3_sb_empty", sb.size(), 0);

      d0 = done_cnt;
      send(8'hA5);
      chk("t4_overflow_cleared", 32'(err_overflow), 0);
      chk("t4_active", 32'(frame_active), 1);
      for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
      step(99);
      chk("t4_no_timeout_at_99", 32'(err_timeout), 0);
      chk("t4_active_at_99", 32'(frame_active), 1);
      step(1);
      chk("t4_timeout_at_100", 32'(err_timeout), 1);
      chk("t4_idle_after_timeout", 32'(frame_active), 0);
      chk("t4_no_frame_done", done_cnt - d0, 0);
      send(8'hA5);
      chk("t4_timeout_cleared", 32'(err_timeout), 0);

      for (int i = 0; i < 7; i++) send(8'h60 + 8'(i));
      rx_data  = 8'h67;
      rx_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk("t5_outputs_in_reset", all_outs(), 0);
      step(2);
      chk("t5_outputs_held_reset", all_outs(), 0);
      rx_valid   = 1'b0;
      rst_n      = 1'b1;
      exp_frames = 0;
      step(2);
      tx0 = tx_cnt;
      frame(8'h80, 12, 4);
      wait_done("t5_done");
      chk("t5_tx_count", tx_cnt - tx0, 4 + TRL);
      chk("t5_sb_empty", sb.size(), 0);

      frame(8'hC0, 12, 4);
      wait_done("t6_done");
      chk("t6_sb_empty", sb.size(), 0);
      chk("t6_total_frames", done_cnt, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sobel_frame_sequencer.md
# sobel_frame_sequencer

Frame-level controller for the UART Sobel edge-detection path. It sits between the UART receiver, the Sobel filter datapath and the UART transmitter. It detects the start of each frame, clears and feeds the filter, and tracks row and column position so that only interior (fully windowed) results are returned. It buffers those results in a small FIFO and paces them into the UART transmitter with a start/busy handshake.

## Interface
Parameters:
- IMG_W, 320: pixels per row (at least 3).
- IMG_H, 240: rows per frame (at least 3).
- FILT_LAT, 1: cycles from filt_in_valid to the matching filt_out_valid.
- FIFO_DEPTH, 8: TX FIFO entries (power of two).
- TIMEOUT_CYC, 50000000: idle-cycle limit while receiving a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe for rx_data.
- filt_clear  out  1  one-cycle pulse that clears the filter line buffers and window.
- filt_in_data  out  8  pixel to the filter.
- filt_in_valid  out  1  pixel strobe to the filter.
- filt_out_data  in  8  filter result.
- filt_out_valid  in  1  result strobe, FILT_LAT cycles after filt_in_valid.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy.
- frame_active  out  1  high in RECV and DRAIN.
- frame_done  out  1  one-cycle pulse at the end of a completed frame.
- err_timeout  out  1  sticky.
- err_overflow  out  1  sticky.

## Operation
- States: IDLE, RECV, DRAIN, TRAIL (macro only).
- IDLE:
  - rx_data == SYNC_BYTE (0xA5) with rx_valid moves to RECV.
  - In the same transition: col/row cleared, both error flags cleared, filt_clear pulsed.
  - Any other byte is discarded.
- RECV:
  - Each rx_valid is forwarded as filt_in_valid/filt_in_data.
  - col increments and wraps at IMG_W-1, at which point row increments.
  - A byte received at (row, col) is tagged interior when row ≥ 2 and col ≥ 2.
  - The tag travels through a FILT_LAT-deep shift register aligned with the filter.
  - Accepting the byte at row IMG_H-1, col IMG_W-1 moves to DRAIN.
- Result path:
  - On filt_out_valid with the aligned tag = 1, filt_out_data is pushed to the FIFO.
  - Untagged results are dropped.
  - Exactly (IMG_W-2)·(IMG_H-2) bytes are returned per frame.
- TX pacing (sub-FSM TX_IDLE → TX_WAIT_HI → TX_WAIT_LO):
  - In TX_IDLE, with FIFO non-empty and tx_busy low: pop, drive tx_data, pulse tx_start, go to TX_WAIT_HI.
  - TX_WAIT_HI advances on tx_busy = 1.
  - TX_WAIT_LO returns to TX_IDLE on tx_busy = 0.
- DRAIN: leaves when all of the following hold, then pulses frame_done and goes to IDLE (or TRAIL).
  - Tag pipeline empty.
  - FIFO empty.
  - TX sub-FSM in TX_IDLE.
  - tx_busy = 0.
- Boundary cases:
  - FIFO full on push: byte dropped, err_overflow set.
  - Push and pop in the same cycle: both proceed, count unchanged.
  - rx_valid during DRAIN: ignored.
  - SYNC_BYTE seen mid-frame: treated as pixel data.
  - RECV idle for TIMEOUT_CYC consecutive cycles: err_timeout set, FIFO and tag pipeline flushed, return to IDLE, no frame_done pulse. A byte already handed to the transmitter completes, and the TX sub-FSM still finishes its handshake.
- Reset mid-operation:
  - All state returns to IDLE / TX_IDLE.
  - FIFO, counters and pipeline are emptied.

## Timing
- Reset values: filt_clear, filt_in_valid, tx_start, frame_active, frame_done, err_timeout, err_overflow = 0; filt_in_data = 0; tx_data = 0.
- filt_clear is asserted in the cycle after the sync byte's rx_valid.
- filt_in_valid/filt_in_data are registered: 1 cycle after rx_valid.
- FIFO push occurs on the cycle of filt_out_valid. The earliest tx_start for that byte is 2 cycles later (push, then pop).
- tx_start is never asserted while tx_busy = 1 or outside TX_IDLE.
- frame_active rises 1 cycle after the sync byte and falls together with the frame_done pulse.
- The timeout counter resets on every rx_valid and counts only in RECV.

## Configuration
- SOBEL_SEQ_TRAILER_EN:
  - Defined: DRAIN goes to TRAIL, which transmits 0x5A followed by the 8-bit frame counter (completed frames, wraps at 255) through the same TX handshake, then goes to IDLE. frame_done pulses on leaving TRAIL.
  - Undefined: no TRAIL state, no frame counter, and DRAIN goes to IDLE directly.

## Structure
- Package sobel_seq_pkg holds:
  - The main-FSM and TX-FSM state enums.
  - The constants SYNC_BYTE = 8'hA5 and TRAILER_BYTE = 8'h5A.
- Sub-module seq_byte_fifo: synchronous FIFO of width 8 and depth FIFO_DEPTH, with push, pop, full, empty, asynchronous active-low reset and a synchronous flush input.

## Test plan
All scenarios use IMG_W = 4, IMG_H = 4, FILT_LAT = 1 and a filter model that echoes its input.
- Send 0xA5 then bytes 0..15; tx_busy model holds 10 cycles per byte → filt_clear pulses once, tx bytes are 10, 11, 14, 15 in order, and frame_done pulses once.
- Send 0x11, 0x22, then 0xA5 and 16 pixels → both leading bytes are dropped, filt_in_valid pulses exactly 16 times, and 4 bytes are returned.
- Hold tx_busy = 1 throughout a frame of pixels sent back-to-back with FIFO_DEPTH = 2 → err_overflow = 1, and exactly 2 bytes are sent after tx_busy releases.
- With TIMEOUT_CYC = 100: send 0xA5 and 5 pixels, then stay idle → err_timeout = 1 at idle cycle 100, state IDLE, no frame_done; the next 0xA5 clears err_timeout.
- Assert rst low during pixel 7 and release it, then send a full frame → all outputs are 0 during reset and the new frame returns exactly 4 correct bytes.
- With SOBEL_SEQ_TRAILER_EN defined, send two frames → each frame ends with 0x5A, 0x01 and then 0x5A, 0x02.
